// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundle for cacheline_burst_adaptor: cache-side line port plus memory-side burst port.
`timescale 1ns/1ps
interface cacheline_burst_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic               pmem_read;
  logic               pmem_write;
  logic [31:0]        pmem_address;
  logic [LINE_W-1:0]  pmem_wdata;
  logic [LINE_W-1:0]  pmem_rdata;
  logic               pmem_resp;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               timeout;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
    output pmem_rdata, pmem_resp, burst_o, address_o, read_o, write_o, timeout
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
    input  pmem_rdata, pmem_resp, burst_o, address_o, read_o, write_o, timeout
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts a cache line read/write into a LINE_W/BURST_W-beat memory burst.
// Optional watchdog enabled by CACHELINE_ADAPTOR_TIMEOUT_EN.
`timescale 1ns/1ps
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  cacheline_burst_adaptor_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic [LINE_W-1:0]  wline_q;
  logic [LINE_W-1:0]  rdata_q;
  logic [BURST_W-1:0] burst_q;
  logic [31:0]        addr_q;
  logic               rd_q;
  logic               wr_q;
  logic               resp_q;
  logic               last_beat;

  assign cnt_d     = cnt_q + CW'(1);
  assign last_beat = (cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wline_q <= '0;
      rdata_q <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.pmem_write) begin
            state_q <= WR_BURST;
            addr_q  <= {bus.pmem_address[31:OFF_W], OFF_W'(0)};
            wline_q <= bus.pmem_wdata;
            burst_q <= bus.pmem_wdata[BURST_W-1:0];
            wr_q    <= 1'b1;
          end else if (bus.pmem_read) begin
            state_q <= RD_BURST;
            addr_q  <= {bus.pmem_address[31:OFF_W], OFF_W'(0)};
            rd_q    <= 1'b1;
          end
        end
        RD_BURST: if (bus.resp_i) begin
          rdata_q[cnt_q*BURST_W +: BURST_W] <= bus.burst_i;
          cnt_q <= cnt_d;
          if (last_beat) begin
            state_q <= DONE;
            rd_q    <= 1'b0;
            resp_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        WR_BURST: if (bus.resp_i) begin
          cnt_q   <= cnt_d;
          // Pre-load the next slice so burst_o is valid while write_o waits for resp_i.
          burst_q <= wline_q[cnt_d*BURST_W +: BURST_W];
          if (last_beat) begin
            state_q <= DONE;
            wr_q    <= 1'b0;
            resp_q  <= 1'b1;
            burst_q <= '0;
            cnt_q   <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_resp  = resp_q;
  assign bus.burst_o    = burst_q;
  assign bus.address_o  = addr_q;
  assign bus.read_o     = rd_q;
  assign bus.write_o    = wr_q;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       to_q;
  logic       busy;

  assign busy = (state_q == RD_BURST) || (state_q == WR_BURST);

  // Saturating count of silent burst cycles; timeout is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (!busy || bus.resp_i) wd_q <= '0;
      else if (wd_q != 8'hFF)  wd_q <= wd_q + 8'd1;
      if (busy && !bus.resp_i && wd_q == 8'hFE) to_q <= 1'b1;
    end
  end

  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor: directed table, hand sequences, random transactions.
`timescale 1ns/1ps
module tb_cacheline_burst_adaptor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if #(.LINE_W(256), .BURST_W(64)) bus();

  cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_rdata = '0;
  logic         exp_to    = 1'b0;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [31:0]  pat;
    logic [31:0]  exp_addr;
    logic [255:0] exp_rdata;
  } vec_t;
  vec_t vec[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_read_o", 256'(bus.read_o), 256'(0));
    chk("idle_write_o", 256'(bus.write_o), 256'(0));
    chk("idle_resp", 256'(bus.pmem_resp), 256'(0));
    chk("idle_rdata", bus.pmem_rdata, exp_rdata);
    chk("idle_timeout", 256'(bus.timeout), 256'(exp_to));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.resp_i  = 1'($urandom_range(0, 1));
      bus.burst_i = {$urandom, $urandom};
      @(negedge clk);
      chk_idle();
    end
  endtask

  // One line transaction; beat j of the memory side is line[64j +: 64], resp_i follows pat bits.
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] line,
                      input logic [31:0] pat, input logic [31:0] exp_a);
    int beats = 0;
    bit fin = 0;
    logic [255:0] exp_line;
    exp_line = (!wr && rd) ? line : exp_rdata;
    @(posedge clk); #1;
    bus.pmem_write   = wr;
    bus.pmem_read    = rd;
    bus.pmem_address = a;
    bus.pmem_wdata   = line;
    bus.resp_i       = 1'($urandom_range(0, 1));
    bus.burst_i      = {$urandom, $urandom};
    @(negedge clk);
    chk("req_cycle_busy", 256'({bus.read_o, bus.write_o}), 256'(0));
    for (int c = 1; c < 80 && !fin; c++) begin
      @(posedge clk); #1;
      bus.pmem_address = $urandom;
      bus.pmem_wdata   = {8{$urandom}};
      if (beats < 4) begin
        bus.resp_i  = (c <= 32) ? pat[c-1] : 1'b1;
        bus.burst_i = bus.resp_i ? line[beats*64 +: 64] : {$urandom, $urandom};
      end else begin
        bus.resp_i  = 1'($urandom_range(0, 1));
        bus.burst_i = {$urandom, $urandom};
      end
      @(negedge clk);
      if (beats < 4) begin
        chk("read_o", 256'(bus.read_o), 256'(!wr));
        chk("write_o", 256'(bus.write_o), 256'(wr));
        chk("early_resp", 256'(bus.pmem_resp), 256'(0));
        chk("address_o", 256'(bus.address_o), 256'(exp_a));
        if (wr) chk("burst_o", 256'(bus.burst_o), 256'(line[beats*64 +: 64]));
      end else begin
        chk("pmem_resp", 256'(bus.pmem_resp), 256'(1));
        chk("done_rw", 256'({bus.read_o, bus.write_o}), 256'(0));
        chk("rdata", bus.pmem_rdata, exp_line);
        fin = 1;
      end
      chk("timeout", 256'(bus.timeout), 256'(exp_to));
      if (beats < 4 && bus.resp_i) beats++;
    end
    if (!fin) chk("resp_budget", 256'(0), 256'(1));
    exp_rdata = exp_line;
    @(posedge clk); #1;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.resp_i     = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit act=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  a, p;
    bit           w, r;

    vec[0] = '{0, 1, 32'h0000_1234,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               32'h0000_000F, 32'h0000_1220,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vec[1] = '{1, 0, 32'h8000_00E0,
               {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A},
               32'h0000_00B5, 32'h8000_00E0,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vec[2] = '{0, 1, 32'h0000_4ABC,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_5A5A_A5A5, 64'hDEAD_BEEF_CAFE_F00D},
               32'h0000_0059, 32'h0000_4AA0,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_5A5A_A5A5, 64'hDEAD_BEEF_CAFE_F00D}};
    vec[3] = '{1, 1, 32'hFFFF_FFFF,
               {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666},
               32'h0000_000F, 32'hFFFF_FFE0,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_5A5A_A5A5, 64'hDEAD_BEEF_CAFE_F00D}};

    bus.pmem_read = 1'b0; bus.pmem_write = 1'b0; bus.pmem_address = '0;
    bus.pmem_wdata = '0; bus.burst_i = '0; bus.resp_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", bus.pmem_rdata, 256'(0));
    chk("rst_outs", 256'({bus.pmem_resp, bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.timeout}), 256'(0));
    rst = 1'b1;
    idle(2);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      xfer(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].line, vec[i].pat, vec[i].exp_addr);
      chk("tbl_rdata", bus.pmem_rdata, vec[i].exp_rdata);
      idle(1);
    end

    // Reset mid-burst after two beats
    @(posedge clk); #1;
    bus.pmem_read = 1'b1; bus.pmem_address = 32'h0000_5678;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      bus.resp_i = 1'b1; bus.burst_i = {$urandom | 32'h1, $urandom};
    end
    @(posedge clk); #1;
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_read_o", 256'(bus.read_o), 256'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rdata", bus.pmem_rdata, 256'(0));
    chk("mid_rst_outs", 256'({bus.pmem_resp, bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.timeout}), 256'(0));
    bus.pmem_read = 1'b0;
    exp_rdata = '0;
    exp_to    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    xfer(0, 1, 32'h0000_5678, {64'hF4, 64'hF3, 64'hF2, 64'hF1}, 32'h0000_000F, 32'h0000_5660);

    // Random transactions against the transaction-level model
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 2))
        0: begin w = 1; r = 0; end
        1: begin w = 0; r = 1; end
        default: begin w = 1; r = 1; end
      endcase
      a = $urandom;
      l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      p = $urandom | $urandom;
      if ($countones(p[15:0]) < 4) p[3:0] = 4'hF;
      xfer(w, r, a, l, p, {a[31:5], 5'b0});
      idle($urandom_range(0, 2));
    end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    // Watchdog: 255 silent cycles in RD_BURST, then a normal completion
    l = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
    @(posedge clk); #1;
    bus.pmem_read = 1'b1; bus.pmem_write = 1'b0; bus.pmem_address = 32'h0000_9000; bus.resp_i = 1'b0;
    for (int c = 1; c <= 255; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (c == 1 || c == 255) chk("to_before", 256'(bus.timeout), 256'(0));
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_set", 256'(bus.timeout), 256'(1));
      chk("to_still_read", 256'(bus.read_o), 256'(1));
    end
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      bus.resp_i = 1'b1; bus.burst_i = l[b*64 +: 64];
    end
    @(posedge clk); #1;
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("to_resp", 256'(bus.pmem_resp), 256'(1));
    chk("to_rdata", bus.pmem_rdata, l);
    exp_rdata = l;
    exp_to    = 1'b1;
    @(posedge clk); #1;
    bus.pmem_read = 1'b0;
    @(negedge clk);
    chk_idle();
    idle(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cacheline_burst_adaptor.md
# cacheline_burst_adaptor

Memory-side responder for the cache's physical-memory port. It accepts a 256-bit line read or write from the cache (`pmem_read`/`pmem_write`, `pmem_address`, `pmem_wdata`) and converts it into a 4-beat, 64-bit burst on the main-memory bus. It then returns `pmem_resp`, plus `pmem_rdata` for reads, once the burst completes. It sits between the instruction/data cache datapaths and the DRAM model, one instance per cache.

## Interface
- `LINE_W`, 256, cacheline width in bits.
- `BURST_W`, 64, memory bus beat width; beats per line = LINE_W/BURST_W = 4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pmem_read`  in  1  cache line-read request; level, held until `pmem_resp`.
- `pmem_write`  in  1  cache line-write request; level, held until `pmem_resp`.
- `pmem_address`  in  32  line address from cache; bits [4:0] ignored.
- `pmem_wdata`  in  LINE_W  write line; sampled when the request is accepted.
- `pmem_rdata`  out  LINE_W  assembled read line.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `burst_i`  in  BURST_W  read beat from memory.
- `resp_i`  in  1  memory beat strobe; one beat per high cycle.
- `burst_o`  out  BURST_W  write beat to memory.
- `address_o`  out  32  burst address; {line_addr[31:5], 5'b0}.
- `read_o`  out  1  memory burst read request.
- `write_o`  out  1  memory burst write request.
- `timeout`  out  1  sticky watchdog flag (see Configuration).

## Operation
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE: if `pmem_write`, latch address and `pmem_wdata` and go to WR_BURST. Else if `pmem_read`, latch address and go to RD_BURST. Write wins when both are high.
- RD_BURST: `read_o`=1. Each `resp_i` cycle stores `burst_i` into beat slot `cnt` and increments the 2-bit `cnt`. Beat 0 is line bits [63:0], beat 3 is [255:192]. On the 4th beat go to DONE.
- WR_BURST: `write_o`=1. `burst_o` = latched line slice `cnt`. Each `resp_i` increments `cnt`. The 4th `resp_i` goes to DONE.
- DONE: `pmem_resp`=1 for exactly this cycle, `read_o`/`write_o`=0, `cnt` cleared. Always returns to IDLE next cycle.
- Gaps in `resp_i` within a burst are legal; the count only advances on `resp_i`=1.
- `resp_i` in IDLE or DONE is ignored.
- `pmem_rdata` holds the last assembled line until the next read burst overwrites it. Write bursts do not disturb it.
- `address_o` is the latched address and is stable for the whole burst. Changes on `pmem_address` mid-burst are ignored.
- Reset (any time, including mid-burst): state=IDLE, cnt=0, and every output 0: `pmem_rdata`, `pmem_resp`, `burst_o`, `address_o`, `read_o`, `write_o`, `timeout`. A partial burst is abandoned.

## Timing
- Request accepted at the first edge with `pmem_read`/`pmem_write` high in IDLE. `read_o`/`write_o` are registered and rise the next cycle.
- `burst_o` shows beat 0 in the same cycle `write_o` rises.
- `pmem_resp` rises the cycle after the edge that samples the 4th `resp_i`. With back-to-back beats, latency from request to `pmem_resp` = 6 cycles.
- `pmem_rdata` is valid in the `pmem_resp` cycle.
- The cache must drop its request in the cycle after `pmem_resp`. A request still high in the first IDLE cycle after DONE starts a new burst.

## Configuration
- `CACHELINE_ADAPTOR_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts consecutive RD_BURST/WR_BURST cycles without `resp_i`, reset by `resp_i` and in IDLE.
  - Reaching 255 sets `timeout`, which stays high until reset. The FSM keeps waiting.
- `CACHELINE_ADAPTOR_TIMEOUT_EN` not defined: no counter; `timeout` tied to 0.

## Test plan
- Read: `pmem_read`, addr 0x0000_1234, `resp_i` high 4 consecutive cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> `address_o`=0x0000_1220, `read_o` high 4 cycles, `pmem_resp` pulse at cycle 6, `pmem_rdata`={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write: `pmem_write`, addr 0x8000_00E0, wdata = beats A,B,C,D -> `burst_o` sequence A,B,C,D advancing only on `resp_i`; one `pmem_resp` pulse after the 4th.
- Gapped read: `resp_i` pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; `pmem_resp` once.
- Read and write together: both requests high -> write burst only; `pmem_rdata` unchanged.
- Reset mid-burst: `rst`=0 after 2 beats -> all outputs 0 immediately. A new read after release restarts at beat 0.
- With `CACHELINE_ADAPTOR_TIMEOUT_EN`: `read_o` high and no `resp_i` for 255 cycles -> `timeout`=1 and stays 1. A later 4-beat response still completes with `pmem_resp`.
